// File: rtl/seq_alu.sv
// seq_alu: clocked ALU sitting between the datapath operands and the Z register pair.
//   Single-cycle ops: ADD SUB SHR SHRA SHL ROR ROL AND OR NEG NOT (result in Clow).
//   Multi-cycle ops:  MUL  signed radix-4 Booth, one recoded digit per cycle
//                     DIV  signed non-restoring, one quotient bit per cycle, then a fix-up cycle
// Ports:
//   clock        rising-edge clock for all state
//   clear        synchronous active-high reset, aborts any operation in flight
//   start        one-cycle request, accepted only in IDLE or DONE
//   op           opcode (OPW bits)
//   A, B         operands (WIDTH bits)
//   busy         high while a MUL/DIV iterates
//   done         one-cycle pulse, Chigh/Clow valid from this cycle on
//   Chigh, Clow  result pair (MUL product, DIV remainder/quotient, else {0, result})
//   div_by_zero  set with done for DIV by zero, cleared on the next accepted start
module seq_alu #(
   parameter int WIDTH = 32,
   parameter int OPW   = 5
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic [OPW-1:0]   op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Chigh,
   output logic [WIDTH-1:0] Clow,
   output logic             div_by_zero
);

   localparam int W2 = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH);

   localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
   localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
   localparam logic [OPW-1:0] OP_SHR  = OPW'(5'b00101);
   localparam logic [OPW-1:0] OP_SHRA = OPW'(5'b00110);
   localparam logic [OPW-1:0] OP_SHL  = OPW'(5'b00111);
   localparam logic [OPW-1:0] OP_ROR  = OPW'(5'b01000);
   localparam logic [OPW-1:0] OP_ROL  = OPW'(5'b01001);
   localparam logic [OPW-1:0] OP_AND  = OPW'(5'b01010);
   localparam logic [OPW-1:0] OP_OR   = OPW'(5'b01011);
   localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b01111);
   localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b10000);
   localparam logic [OPW-1:0] OP_NEG  = OPW'(5'b10001);
   localparam logic [OPW-1:0] OP_NOT  = OPW'(5'b10010);

   localparam logic [CW-1:0]    MUL_LAST = CW'(WIDTH / 2 - 1);
   localparam logic [CW-1:0]    DIV_LAST = CW'(WIDTH - 1);
   localparam logic [W2-1:0]    ONE_W2   = {{(W2 - 1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MUL  = 3'd1,
      ST_DIV  = 3'd2,
      ST_DFIX = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   state_t           state_r, state_s;
   logic [CW-1:0]    cnt_r;
   logic [W2-1:0]    acc_r, mcand_r, pp_s, acc_sum_s;
   logic [WIDTH:0]   mplier_r;
   logic [WIDTH:0]   rem_r, shifted_s, rem_step_s;
   logic [WIDTH-1:0] quo_r, dvsr_r, quo_step_s, rem_mag_s, rem_out_s, quo_out_s;
   logic [WIDTH-1:0] abs_a_s, abs_b_s;
   logic             neg_a_r, neg_b_r;
   logic             accept_s, is_mul_s, is_div_s, div_zero_s;

   // Result of every single-cycle opcode; unknown opcodes return the 0xCC debug marker.
   function automatic logic [WIDTH-1:0] single_op(
      input logic [OPW-1:0]   o,
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b
   );
      logic [CW-1:0]           amt_s;
      logic                    big_s;
      logic signed [WIDTH-1:0] sra_s;
      logic [WIDTH-1:0]        res_s;
      amt_s = b[CW-1:0];
      // WIDTH is a power of two, so any bit above the rotate field means amount >= WIDTH
      big_s = |b[WIDTH-1:CW];
      sra_s = $signed(a) >>> b;
      res_s = {(WIDTH / 8){8'hCC}};
      case (o)
         OP_ADD:  res_s = a + b;
         OP_SUB:  res_s = a - b;
         OP_SHR:  begin
            if (big_s) res_s = ZERO_W;
            else       res_s = a >> b;
         end
         OP_SHRA: begin
            if (big_s) res_s = {WIDTH{a[WIDTH-1]}};
            else       res_s = sra_s;
         end
         OP_SHL:  begin
            if (big_s) res_s = ZERO_W;
            else       res_s = a << b;
         end
         // rotate through a doubled copy so amount 0 needs no special case
         OP_ROR:  res_s = WIDTH'({a, a} >> amt_s);
         OP_ROL:  res_s = WIDTH'(({a, a} << amt_s) >> WIDTH);
         OP_AND:  res_s = a & b;
         OP_OR:   res_s = a | b;
         OP_NEG:  res_s = ZERO_W - b;
         OP_NOT:  res_s = ~b;
         default: res_s = {(WIDTH / 8){8'hCC}};
      endcase
      return res_s;
   endfunction

   assign accept_s   = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
   assign is_mul_s   = (op == OP_MUL);
   assign is_div_s   = (op == OP_DIV);
   assign div_zero_s = is_div_s && (B == ZERO_W);
   assign abs_a_s    = A[WIDTH-1] ? (ZERO_W - A) : A;
   assign abs_b_s    = B[WIDTH-1] ? (ZERO_W - B) : B;

   // Next-state logic of the sequencing FSM.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (accept_s) begin
               if (is_mul_s)                     state_s = ST_MUL;
               else if (is_div_s && !div_zero_s) state_s = ST_DIV;
               else                              state_s = ST_DONE;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_MUL: begin
            if (cnt_r == MUL_LAST) state_s = ST_DONE;
            else                   state_s = ST_MUL;
         end
         ST_DIV: begin
            if (cnt_r == DIV_LAST) state_s = ST_DFIX;
            else                   state_s = ST_DIV;
         end
         ST_DFIX: state_s = ST_DONE;
         default: state_s = ST_IDLE;
      endcase
   end

   // Booth partial product from the current multiplier bit triple {b[i+1], b[i], b[i-1]}.
   always_comb begin
      pp_s = {W2{1'b0}};
      case (mplier_r[2:0])
         3'b001, 3'b010: pp_s = mcand_r;
         3'b011:         pp_s = mcand_r << 1;
         3'b100:         pp_s = ~(mcand_r << 1) + ONE_W2;
         3'b101, 3'b110: pp_s = ~mcand_r + ONE_W2;
         default:        pp_s = {W2{1'b0}};
      endcase
      acc_sum_s = acc_r + pp_s;
   end

   // Non-restoring divide step plus the final restore and sign correction.
   always_comb begin
      shifted_s  = {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};
      rem_step_s = shifted_s;
      rem_mag_s  = rem_r[WIDTH-1:0];
      rem_out_s  = ZERO_W;
      quo_out_s  = ZERO_W;
      // the partial remainder sign chooses add or subtract; only WIDTH+1 bits are needed
      // because the true value always lies in [-divisor, divisor)
      if (rem_r[WIDTH]) rem_step_s = shifted_s + {1'b0, dvsr_r};
      else              rem_step_s = shifted_s - {1'b0, dvsr_r};
      quo_step_s = {quo_r[WIDTH-2:0], ~rem_step_s[WIDTH]};
      if (rem_r[WIDTH]) rem_mag_s = rem_r[WIDTH-1:0] + dvsr_r;
      else              rem_mag_s = rem_r[WIDTH-1:0];
      // remainder follows the dividend sign, quotient is negative when signs differ
      if (neg_a_r) rem_out_s = ZERO_W - rem_mag_s;
      else         rem_out_s = rem_mag_s;
      if (neg_a_r ^ neg_b_r) quo_out_s = ZERO_W - quo_r;
      else                   quo_out_s = quo_r;
   end

   // FSM state register.
   always_ff @(posedge clock) begin
      if (clear) state_r <= ST_IDLE;
      else       state_r <= state_s;
   end

   // Operand capture, iteration registers and registered outputs.
   always_ff @(posedge clock) begin
      if (clear) begin
         cnt_r       <= {CW{1'b0}};
         acc_r       <= {W2{1'b0}};
         mcand_r     <= {W2{1'b0}};
         mplier_r    <= {(WIDTH + 1){1'b0}};
         rem_r       <= {(WIDTH + 1){1'b0}};
         quo_r       <= ZERO_W;
         dvsr_r      <= ZERO_W;
         neg_a_r     <= 1'b0;
         neg_b_r     <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         Chigh       <= ZERO_W;
         Clow        <= ZERO_W;
         div_by_zero <= 1'b0;
      end else begin
         busy <= (state_s == ST_MUL) || (state_s == ST_DIV) || (state_s == ST_DFIX);
         done <= (state_s == ST_DONE);
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (accept_s) begin
                  div_by_zero <= 1'b0;
                  cnt_r       <= {CW{1'b0}};
                  acc_r       <= {W2{1'b0}};
                  mcand_r     <= {{WIDTH{A[WIDTH-1]}}, A};
                  mplier_r    <= {B, 1'b0};
                  rem_r       <= {(WIDTH + 1){1'b0}};
                  quo_r       <= abs_a_s;
                  dvsr_r      <= abs_b_s;
                  neg_a_r     <= A[WIDTH-1];
                  neg_b_r     <= B[WIDTH-1];
                  if (div_zero_s) begin
                     Chigh       <= A;
                     Clow        <= {WIDTH{1'b1}};
                     div_by_zero <= 1'b1;
                  end else if (!is_mul_s && !is_div_s) begin
                     Chigh <= ZERO_W;
                     Clow  <= single_op(op, A, B);
                  end
               end
            end
            ST_MUL: begin
               acc_r    <= acc_sum_s;
               mcand_r  <= mcand_r << 2;
               mplier_r <= mplier_r >> 2;
               cnt_r    <= cnt_r + {{(CW - 1){1'b0}}, 1'b1};
               if (cnt_r == MUL_LAST) begin
                  Chigh <= acc_sum_s[W2-1:WIDTH];
                  Clow  <= acc_sum_s[WIDTH-1:0];
               end
            end
            ST_DIV: begin
               rem_r <= rem_step_s;
               quo_r <= quo_step_s;
               cnt_r <= cnt_r + {{(CW - 1){1'b0}}, 1'b1};
            end
            ST_DFIX: begin
               Chigh <= rem_out_s;
               Clow  <= quo_out_s;
            end
            default: begin
               cnt_r <= {CW{1'b0}};
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32): directed corner cases plus random
// vectors compared against a plain-arithmetic reference model.
module tb_seq_alu;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_SHR  = 5'b00101;
   localparam logic [4:0] OP_SHRA = 5'b00110;
   localparam logic [4:0] OP_SHL  = 5'b00111;
   localparam logic [4:0] OP_ROR  = 5'b01000;
   localparam logic [4:0] OP_ROL  = 5'b01001;
   localparam logic [4:0] OP_AND  = 5'b01010;
   localparam logic [4:0] OP_OR   = 5'b01011;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;

   logic        clock = 1'b0;
   logic        clear, start;
   logic [4:0]  op;
   logic [31:0] A, B;
   logic        busy, done, div_by_zero;
   logic [31:0] Chigh, Clow;

   int errors = 0;
   int checks = 0;

   logic [4:0] ops_tbl [0:13] = '{OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
                                  OP_AND, OP_OR, OP_NEG, OP_NOT, 5'b00000, 5'b01100, 5'b11111};

   seq_alu #(.WIDTH(32), .OPW(5)) dut (
      .clock(clock), .clear(clear), .start(start), .op(op), .A(A), .B(B),
      .busy(busy), .done(done), .Chigh(Chigh), .Clow(Clow), .div_by_zero(div_by_zero)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference result {Chigh, Clow} computed with ordinary integer arithmetic.
   function automatic logic [63:0] ref_result(input logic [4:0] o, input logic [31:0] a,
                                              input logic [31:0] b, output logic dz);
      longint      sa, sb, prod;
      int unsigned amt;
      logic [31:0] hi, lo;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      amt = b % 32;
      hi  = 32'h0;
      dz  = 1'b0;
      case (o)
         OP_ADD:  lo = a + b;
         OP_SUB:  lo = a - b;
         OP_SHR:  lo = (b >= 32'd32) ? 32'h0 : (a >> b);
         OP_SHRA: lo = (b >= 32'd32) ? ((sa < 0) ? 32'hFFFF_FFFF : 32'h0) : 32'(sa >>> b);
         OP_SHL:  lo = (b >= 32'd32) ? 32'h0 : (a << b);
         OP_ROR:  lo = (amt == 0) ? a : ((a >> amt) | (a << (32 - amt)));
         OP_ROL:  lo = (amt == 0) ? a : ((a << amt) | (a >> (32 - amt)));
         OP_AND:  lo = a & b;
         OP_OR:   lo = a | b;
         OP_NEG:  lo = 32'h0 - b;
         OP_NOT:  lo = ~b;
         OP_MUL:  begin
            prod = sa * sb;
            hi   = prod[63:32];
            lo   = prod[31:0];
         end
         OP_DIV:  begin
            if (sb == 0) begin
               lo = 32'hFFFF_FFFF;
               hi = a;
               dz = 1'b1;
            end else begin
               prod = sa / sb;
               lo   = prod[31:0];
               prod = sa % sb;
               hi   = prod[31:0];
            end
         end
         default: lo = 32'hCCCC_CCCC;
      endcase
      return {hi, lo};
   endfunction

   function automatic int ref_latency(input logic [4:0] o, input logic [31:0] b);
      if (o == OP_MUL) return 17;
      if (o == OP_DIV) return (b == 32'h0) ? 1 : 34;
      return 1;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 9))
         0:       return 32'h0000_0000;
         1:       return 32'h0000_0001;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Issue one op from a falling edge; return at the falling edge where done is seen.
   task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [63:0] res, output logic dz);
      start = 1'b1; op = o; A = a; B = b;
      @(posedge clock);
      #1 start = 1'b0;
      lat = 0;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clock);
         if (done === 1'b1) begin
            lat = n;
            break;
         end
      end
      res = {Chigh, Clow};
      dz  = div_by_zero;
   endtask

   task automatic run_and_check(input string tag, input logic [4:0] o,
                                input logic [31:0] a, input logic [31:0] b);
      int          lat;
      logic [63:0] res, exp_res;
      logic        dz, dz_exp;
      run_op(o, a, b, lat, res, dz);
      exp_res = ref_result(o, a, b, dz_exp);
      check({tag, "_lat"}, 64'(lat), 64'(ref_latency(o, b)));
      check({tag, "_res"}, res, exp_res);
      check({tag, "_dbz"}, {63'h0, dz}, {63'h0, dz_exp});
      check({tag, "_busy"}, {63'h0, busy}, 64'h0);
   endtask

   initial begin
      int          lat;
      logic        seen;
      logic [63:0] exp_res;
      logic        dz_exp;
      logic [4:0]  o;
      logic [31:0] b;

      clear = 1'b1; start = 1'b0; op = 5'h0; A = 32'h0; B = 32'h0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_busy", {63'h0, busy}, 64'h0);
      check("rst_done", {63'h0, done}, 64'h0);
      check("rst_dbz", {63'h0, div_by_zero}, 64'h0);
      check("rst_result", {Chigh, Clow}, 64'h0);
      clear = 1'b0;
      @(negedge clock);

      // directed corner cases
      run_and_check("mul_m7x6", OP_MUL, 32'hFFFF_FFF9, 32'h0000_0006);
      check("mul_m7x6_val", {Chigh, Clow}, 64'hFFFF_FFFF_FFFF_FFD6);
      run_and_check("mul_minxmin", OP_MUL, 32'h8000_0000, 32'h8000_0000);
      check("mul_minxmin_val", {Chigh, Clow}, 64'h4000_0000_0000_0000);
      run_and_check("div_m7d2", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
      check("div_m7d2_val", {Chigh, Clow}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_and_check("div_7d0", OP_DIV, 32'h0000_0007, 32'h0000_0000);
      check("div_7d0_val", {Chigh, Clow}, 64'h0000_0007_FFFF_FFFF);
      run_and_check("add_clr_dbz", OP_ADD, 32'h0000_0005, 32'h0000_0003);
      run_and_check("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      run_and_check("shra_b40", OP_SHRA, 32'h8000_0000, 32'd40);
      check("shra_b40_val", {32'h0, Clow}, 64'h0000_0000_FFFF_FFFF);
      run_and_check("shl_b32", OP_SHL, 32'h1234_5678, 32'd32);
      run_and_check("ror_b33", OP_ROR, 32'h0000_0001, 32'd33);
      check("ror_b33_val", {32'h0, Clow}, 64'h0000_0000_8000_0000);
      run_and_check("undef_op", 5'b00000, 32'h1111_1111, 32'h2222_2222);
      run_and_check("mul_nz", OP_MUL, 32'h0001_2345, 32'h0000_0777);

      // clear in the middle of a MUL aborts it and zeroes the outputs
      start = 1'b1; op = OP_MUL; A = 32'h0000_0123; B = 32'h0000_0456;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (4) @(negedge clock);
      clear = 1'b1;
      @(posedge clock);
      #1 clear = 1'b0;
      @(negedge clock);
      check("abort_busy", {63'h0, busy}, 64'h0);
      check("abort_result", {Chigh, Clow}, 64'h0);
      seen = 1'b0;
      repeat (25) begin
         @(negedge clock);
         if (done === 1'b1) seen = 1'b1;
      end
      check("abort_no_done", {63'h0, seen}, 64'h0);

      // an ADD start while DIV is busy must be ignored
      start = 1'b1; op = OP_DIV; A = 32'hFFFF_FF9C; B = 32'h0000_0007;
      @(posedge clock);
      #1 start = 1'b0;
      @(negedge clock);
      check("hs_busy", {63'h0, busy}, 64'h1);
      start = 1'b1; op = OP_ADD; A = 32'h0000_0001; B = 32'h0000_0002;
      @(posedge clock);
      #1 start = 1'b0;
      lat = 0;
      for (int n = 2; n <= 60; n++) begin
         @(negedge clock);
         if (done === 1'b1) begin
            lat = n;
            break;
         end
      end
      exp_res = ref_result(OP_DIV, 32'hFFFF_FF9C, 32'h0000_0007, dz_exp);
      check("hs_lat", 64'(lat), 64'd34);
      check("hs_res", {Chigh, Clow}, exp_res);
      // start issued in the DONE cycle is accepted immediately
      run_and_check("hs_start_in_done", OP_SUB, 32'h0000_0010, 32'h0000_0020);

      // random signed MUL/DIV including edge operands
      for (int i = 0; i < 400; i++) begin
         o = (i % 2 == 0) ? OP_MUL : OP_DIV;
         run_and_check((o == OP_MUL) ? "rnd_mul" : "rnd_div", o, pick(), pick());
      end

      // random single-cycle ops, shift amounts biased to straddle the width
      for (int i = 0; i < 300; i++) begin
         o = ops_tbl[$urandom_range(0, 13)];
         b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 70)) : pick();
         run_and_check("rnd_single", o, pick(), b);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
